// File: rtl/aes_byte_stream_ctrl_if.sv
// Bundle of the byte-stream handshakes and the AES wrapper bus for aes_byte_stream_ctrl.
// slave = the controller's view; master = the surrounding system's view.
interface aes_byte_stream_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             encrypt;
  logic [127:0]     key_in;
  logic             core_start;
  logic             core_encrypt;
  logic [127:0]     core_data;
  logic [127:0]     core_key;
  logic             core_busy;
  logic             core_done;
  logic [127:0]     core_result;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             timeout_err;
  logic [CNT_W-1:0] blk_count;

  modport slave (
    input  in_valid, in_data, encrypt, key_in,
    input  core_busy, core_done, core_result,
    input  out_ready,
    output in_ready, core_start, core_encrypt, core_data, core_key,
    output out_valid, out_data, timeout_err, blk_count
  );

  modport master (
    output in_valid, in_data, encrypt, key_in,
    output core_busy, core_done, core_result,
    output out_ready,
    input  in_ready, core_start, core_encrypt, core_data, core_key,
    input  out_valid, out_data, timeout_err, blk_count
  );
endinterface

// File: rtl/aes_byte_stream_ctrl.sv
// Byte-serial front/back end for a start/done AES wrapper: packs 16 bytes into a block,
// issues it, waits (with timeout) for the result and streams it back out as 16 bytes.
module aes_byte_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_byte_stream_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q,     state_d;
  logic [3:0]        byte_cnt_q,  byte_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [127:0]      data_q,      data_d;
  logic [127:0]      key_q,       key_d;
  logic              enc_q,       enc_d;
  logic [127:0]      shift_q,     shift_d;
  logic [CNT_W-1:0]  blk_q,       blk_d;
  logic              terr_q,      terr_d;

  logic in_ready;
  logic core_start;
  logic out_valid;
  logic core_busy_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      data_q     <= '0;
      key_q      <= '0;
      enc_q      <= 1'b0;
      shift_q    <= '0;
      blk_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      key_q      <= key_d;
      enc_q      <= enc_d;
      shift_q    <= shift_d;
      blk_q      <= blk_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    key_d      = key_q;
    enc_d      = enc_q;
    shift_d    = shift_q;
    blk_d      = blk_q;
    terr_d     = 1'b0;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          // Shifting in from the bottom leaves the first byte in [127:120] after 16 bytes.
          data_d = {data_q[119:0], bus.in_data};
          if (byte_cnt_q == 4'd0) begin
            key_d = bus.key_in;
            enc_d = bus.encrypt;
          end
          if (byte_cnt_q == 4'd15) begin
            byte_cnt_d = '0;
            state_d    = S_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end

      S_ISSUE: begin
        core_start = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (bus.core_done) begin
          shift_d = bus.core_result;
          state_d = S_DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          shift_d = {shift_q[119:0], 8'h00};
          if (byte_cnt_q == 4'd15) begin
            byte_cnt_d = '0;
            blk_d      = blk_q + CNT_W'(1);
            state_d    = S_FILL;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // core_busy is informational only; sequencing relies solely on core_done.
  assign core_busy_unused = bus.core_busy;

  assign bus.in_ready     = in_ready;
  assign bus.core_start   = core_start;
  assign bus.core_encrypt = enc_q;
  assign bus.core_data    = data_q;
  assign bus.core_key     = key_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = shift_q[127:120];
  assign bus.timeout_err  = terr_q;
  assign bus.blk_count    = blk_q;

endmodule

// File: tb/tb_aes_byte_stream_ctrl.sv
// Self-checking bench for aes_byte_stream_ctrl: a stub AES wrapper answers 2 cycles after
// core_start; expected bytes come from a block-level model (assembled block -> cipher -> bytes).
`timescale 1ns/1ps
module tb_aes_byte_stream_ctrl;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  aes_byte_stream_ctrl_if #(.CNT_W(CW)) bus ();

  aes_byte_stream_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Wrapper stand-in: the FIPS-197 vector is answered exactly, other blocks use a keyed permutation.
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k, input logic e);
    if (e && d == PT && k == K) return CT;
    if (!e && d == CT && k == K) return PT;
    return e ? ({d[119:0], d[127:120]} ^ k) : ({d[7:0], d[127:8]} ^ ~k);
  endfunction

  logic         stub_done = 1'b0;
  logic [127:0] stub_result = '0;
  logic         stub_mute = 1'b0;
  logic         spur_done = 1'b0;
  logic [127:0] spur_result = '0;

  assign bus.core_done   = stub_done | spur_done;
  assign bus.core_result = spur_done ? spur_result : stub_result;

  initial begin
    logic [127:0] r;
    bus.core_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_start && !rst) begin
        r = cipher(bus.core_data, bus.core_key, bus.core_encrypt);
        bus.core_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (!stub_mute) begin
          stub_done   = 1'b1;
          stub_result = r;
        end
        @(posedge clk); #1;
        stub_done     = 1'b0;
        stub_result   = {$urandom, $urandom, $urandom, $urandom};
        bus.core_busy = 1'b0;
      end
    end
  end

  // Observation: cycle count, drained bytes, start/timeout events.
  int           cyc = 0;
  logic [7:0]   got[$];
  int           start_cnt = 0;
  int           start_cyc = 0;
  logic [127:0] st_data = '0;
  logic [127:0] st_key = '0;
  logic         st_enc = 1'b0;
  int           terr_cnt = 0;
  int           terr_cyc = 0;
  int           overlap_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      if (bus.core_start) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
        st_data   <= bus.core_data;
        st_key    <= bus.core_key;
        st_enc    <= bus.core_encrypt;
      end
      if (bus.timeout_err) begin
        terr_cnt <= terr_cnt + 1;
        terr_cyc <= cyc;
      end
      if (bus.out_valid && bus.in_ready) overlap_cnt <= overlap_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [127:0] blk, input logic [127:0] key, input logic enc,
                            input int gap_pct, input bit scramble);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < 16 && guard < 400) begin
      bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = blk[127-8*i -: 8];
      if (i == 0) begin
        bus.encrypt = enc;
        bus.key_in  = key;
      end else if (scramble) begin
        bus.encrypt = 1'($urandom_range(0, 1));
        bus.key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    cmp_cnt++;
    if (i != 16) begin
      err_cnt++;
      $display("FAIL fill_accept: accepted %0d bytes, required 16", i);
    end
  endtask

  task automatic wait_drain(input int target, input int bp_pct);
    int guard = 0;
    while (got.size() < target && guard < 400) begin
      bus.out_ready = ($urandom_range(0, 99) >= bp_pct);
      @(posedge clk); #1;
      guard++;
    end
    bus.out_ready = 1'b1;
    cmp_cnt++;
    if (got.size() < target) begin
      err_cnt++;
      $display("FAIL drain_bound: got %0d bytes, required %0d", got.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.encrypt = 1'b0; bus.key_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.core_start !== 1'b0 ||
        bus.timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b core_start=%b timeout_err=%b, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.core_start, bus.timeout_err);
    end
    cmp_cnt++;
    if (bus.blk_count !== '0 || bus.core_data !== '0 || bus.core_key !== '0 ||
        bus.core_encrypt !== 1'b0 || bus.out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_data: blk_count=%0h core_data=%h core_key=%h enc=%b out_data=%h, required all zero",
               bus.blk_count, bus.core_data, bus.core_key, bus.core_encrypt, bus.out_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_encrypt();
    int base = got.size();
    int s0 = start_cnt;
    int t0 = cyc;
    logic [127:0] exp = CT;
    bus.out_ready = 1'b1;
    send_block(PT, K, 1'b1, 0, 1'b0);
    wait_drain(base + 16, 0);
    cmp_cnt++;
    if (cyc - t0 != 35) begin
      err_cnt++;
      $display("FAIL fips_latency: %0d cycles, required 35", cyc - t0);
    end
    cmp_cnt++;
    if (start_cnt - s0 != 1 || st_data !== PT || st_key !== K || st_enc !== 1'b1) begin
      err_cnt++;
      $display("FAIL fips_issue: starts=%0d data=%h key=%h enc=%b, required 1 %h %h 1",
               start_cnt - s0, st_data, st_key, st_enc, PT, K);
    end
    for (int j = 0; j < 16; j++) begin
      cmp_cnt++;
      if (got[base+j] !== exp[127-8*j -: 8]) begin
        err_cnt++;
        $display("FAIL fips_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
      end
    end
    cmp_cnt++;
    if (bus.blk_count !== CW'(1) || bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL fips_done: blk_count=%0d in_ready=%b, required 1 1", bus.blk_count, bus.in_ready);
    end
  endtask

  task automatic test_decrypt();
    int base = got.size();
    logic [CW-1:0] b0 = bus.blk_count;
    logic [127:0] exp = PT;
    send_block(CT, K, 1'b0, 0, 1'b1);
    wait_drain(base + 16, 0);
    for (int j = 0; j < 16; j++) begin
      cmp_cnt++;
      if (got[base+j] !== exp[127-8*j -: 8]) begin
        err_cnt++;
        $display("FAIL decrypt_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
      end
    end
    cmp_cnt++;
    if (bus.blk_count !== b0 + CW'(1)) begin
      err_cnt++;
      $display("FAIL decrypt_count: blk_count=%0d, required %0d", bus.blk_count, b0 + CW'(1));
    end
  endtask

  task automatic test_backpressure();
    int base = got.size();
    int ov0 = overlap_cnt;
    logic [CW-1:0] b0 = bus.blk_count;
    logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
    logic enc = 1'($urandom_range(0, 1));
    logic [127:0] exp = cipher(blk, key, enc);
    logic [7:0] hold;
    bit st3 = 0, st15 = 0;
    int guard = 0;
    int n;
    bus.out_ready = 1'b1;
    send_block(blk, key, enc, 0, 1'b0);
    while (got.size() < base + 16 && guard < 400) begin
      n = got.size() - base;
      if (bus.out_valid && ((n == 3 && !st3) || (n == 15 && !st15))) begin
        bus.out_ready = 1'b0;
        hold = bus.out_data;
        cmp_cnt++;
        if (hold !== exp[127-8*n -: 8]) begin
          err_cnt++;
          $display("FAIL bp_present%0d: out_data=%h, required %h", n, hold, exp[127-8*n -: 8]);
        end
        repeat (5) begin
          @(posedge clk); #1;
          cmp_cnt++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== hold || bus.in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_hold%0d: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                     n, bus.out_valid, bus.out_data, bus.in_ready, hold);
          end
        end
        bus.out_ready = 1'b1;
        if (n == 3) st3 = 1; else st15 = 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    cmp_cnt++;
    if (got.size() != base + 16 || overlap_cnt != ov0) begin
      err_cnt++;
      $display("FAIL bp_count: bytes=%0d overlap=%0d, required 16 0", got.size() - base, overlap_cnt - ov0);
    end
    for (int j = 0; j < 16; j++) begin
      cmp_cnt++;
      if (got[base+j] !== exp[127-8*j -: 8]) begin
        err_cnt++;
        $display("FAIL bp_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
      end
    end
    cmp_cnt++;
    if (bus.blk_count !== b0 + CW'(1) || bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_done: blk_count=%0d in_ready=%b, required %0d 1", bus.blk_count, bus.in_ready, b0 + CW'(1));
    end
  endtask

  task automatic test_timeout();
    int base = got.size();
    int e0 = terr_cnt;
    int guard = 0;
    logic [CW-1:0] b0 = bus.blk_count;
    logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] exp = cipher(blk, key, 1'b1);
    stub_mute = 1'b1;
    send_block(blk, key, 1'b0, 0, 1'b0);
    while (terr_cnt == e0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if (terr_cnt - e0 != 1 || terr_cyc - start_cyc != int'(TO) + 1) begin
      err_cnt++;
      $display("FAIL timeout_pulse: pulses=%0d delay_from_wait=%0d, required 1 %0d",
               terr_cnt - e0, terr_cyc - start_cyc - 1, TO);
    end
    cmp_cnt++;
    if (bus.blk_count !== b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || got.size() != base) begin
      err_cnt++;
      $display("FAIL timeout_state: blk_count=%0d in_ready=%b out_valid=%b bytes=%0d, required %0d 1 0 0",
               bus.blk_count, bus.in_ready, bus.out_valid, got.size() - base, b0);
    end
    stub_mute = 1'b0;
    send_block(blk, key, 1'b1, 0, 1'b0);
    wait_drain(base + 16, 0);
    for (int j = 0; j < 16; j++) begin
      cmp_cnt++;
      if (got[base+j] !== exp[127-8*j -: 8]) begin
        err_cnt++;
        $display("FAIL timeout_next_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
      end
    end
    cmp_cnt++;
    if (bus.blk_count !== b0 + CW'(1)) begin
      err_cnt++;
      $display("FAIL timeout_next_count: blk_count=%0d, required %0d", bus.blk_count, b0 + CW'(1));
    end
  endtask

  task automatic test_gapped_spurious();
    for (int it = 0; it < 2; it++) begin
      int base = got.size();
      int s0 = start_cnt;
      int e0 = terr_cnt;
      logic [CW-1:0] b0 = bus.blk_count;
      logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
      logic enc = 1'($urandom_range(0, 1));
      logic [127:0] exp = cipher(blk, key, enc);
      int dly = $urandom_range(3, 10);
      fork
        send_block(blk, key, enc, 40, 1'b1);
        begin
          repeat (dly) @(posedge clk);
          #1;
          spur_result = {$urandom, $urandom, $urandom, $urandom};
          spur_done   = 1'b1;
          @(posedge clk); #1;
          spur_done   = 1'b0;
        end
      join
      wait_drain(base + 16, 30);
      cmp_cnt++;
      if (start_cnt - s0 != 1 || st_data !== blk || st_key !== key || st_enc !== enc || terr_cnt != e0) begin
        err_cnt++;
        $display("FAIL gap_issue: starts=%0d data=%h key=%h enc=%b errs=%0d, required 1 %h %h %b 0",
                 start_cnt - s0, st_data, st_key, st_enc, terr_cnt - e0, blk, key, enc);
      end
      for (int j = 0; j < 16; j++) begin
        cmp_cnt++;
        if (got[base+j] !== exp[127-8*j -: 8]) begin
          err_cnt++;
          $display("FAIL gap_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
        end
      end
      cmp_cnt++;
      if (bus.blk_count !== b0 + CW'(1)) begin
        err_cnt++;
        $display("FAIL gap_count: blk_count=%0d, required %0d", bus.blk_count, b0 + CW'(1));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int base = got.size();
      logic [CW-1:0] b0 = bus.blk_count;
      logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
      logic enc = 1'($urandom_range(0, 1));
      logic [127:0] exp = cipher(blk, key, enc);
      send_block(blk, key, enc, $urandom_range(0, 50), 1'b1);
      wait_drain(base + 16, $urandom_range(0, 60));
      for (int j = 0; j < 16; j++) begin
        cmp_cnt++;
        if (got[base+j] !== exp[127-8*j -: 8]) begin
          err_cnt++;
          $display("FAIL rand%0d_byte%0d: got %h, required %h", it, j, got[base+j], exp[127-8*j -: 8]);
        end
      end
      cmp_cnt++;
      if (bus.blk_count !== b0 + CW'(1)) begin
        err_cnt++;
        $display("FAIL rand%0d_count: blk_count=%0d, required %0d", it, bus.blk_count, b0 + CW'(1));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int base = got.size();
    logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] exp;
    send_block(blk, key, 1'b1, 0, 1'b0);
    wait_drain(base + 7, 0);
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.blk_count !== '0 ||
        bus.timeout_err !== 1'b0 || bus.core_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_ctrl: out_valid=%b in_ready=%b blk_count=%0d terr=%b start=%b, required 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.blk_count, bus.timeout_err, bus.core_start);
    end
    cmp_cnt++;
    if (bus.core_data !== '0 || bus.core_key !== '0 || bus.core_encrypt !== 1'b0 || bus.out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL rst_mid_data: core_data=%h core_key=%h enc=%b out_data=%h, required all zero",
               bus.core_data, bus.core_key, bus.core_encrypt, bus.out_data);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    base = got.size();
    blk = {$urandom, $urandom, $urandom, $urandom};
    exp = cipher(blk, key, 1'b0);
    send_block(blk, key, 1'b0, 20, 1'b0);
    wait_drain(base + 16, 20);
    for (int j = 0; j < 16; j++) begin
      cmp_cnt++;
      if (got[base+j] !== exp[127-8*j -: 8]) begin
        err_cnt++;
        $display("FAIL rst_next_byte%0d: got %h, required %h", j, got[base+j], exp[127-8*j -: 8]);
      end
    end
    cmp_cnt++;
    if (bus.blk_count !== CW'(1)) begin
      err_cnt++;
      $display("FAIL rst_next_count: blk_count=%0d, required 1", bus.blk_count);
    end
  endtask

  initial begin
    test_reset();
    test_fips_encrypt();
    test_decrypt();
    test_backpressure();
    test_timeout();
    test_gapped_spurious();
    test_random();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/aes_byte_stream_ctrl.md
Name: aes_byte_stream_ctrl

Overview:
Byte-serial front/back end for the combinational-core AES wrapper (start/done/busy, 128-bit data and key).
- Input side: assembles 16 incoming bytes into a 128-bit block, then pulses start with the latched mode and key.
- Output side: on done, captures the 128-bit result and streams it out as 16 bytes with valid/ready backpressure.
- Sits between the byte-wide datapath (UART/bus bridge) and the AES wrapper. Processes one block at a time.

Parameters:
TIMEOUT_CYCLES, 8, max cycles spent in WAIT for core_done before the block is abandoned (must be >= 3).
CNT_W, 16, width of the completed-block counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state.
in_valid  input  1  input byte valid.
in_ready  output  1  block accepts input byte (high only in FILL).
in_data  input  8  input byte.
encrypt  input  1  mode for the block: 1 = encrypt, 0 = decrypt. Sampled with the first byte of each block.
key_in  input  128  key. Sampled with the first byte of each block.
core_start  output  1  one-cycle start pulse to the AES wrapper.
core_encrypt  output  1  latched mode to the wrapper.
core_data  output  128  assembled block to the wrapper.
core_key  output  128  latched key to the wrapper.
core_busy  input  1  wrapper busy; informational only, not used for control.
core_done  input  1  wrapper result-valid pulse.
core_result  input  128  wrapper result; valid when core_done is high.
out_valid  output  1  output byte valid.
out_ready  input  1  downstream accepts output byte.
out_data  output  8  output byte.
timeout_err  output  1  one-cycle pulse when a block is abandoned.
blk_count  output  CNT_W  number of blocks fully drained; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state = FILL, byte counter = 0; core_data, core_key, core_encrypt, result shift register = 0; core_start, out_valid, timeout_err, blk_count = 0. Reset asserted mid-block discards that block entirely.
- Byte order, both directions: first byte ↔ bits [127:120], 16th byte ↔ bits [7:0].
- FILL:
  - in_ready = 1; a byte is accepted when in_valid & in_ready.
  - On byte 0, also latch encrypt and key_in into core_encrypt and core_key.
  - On acceptance of the 16th byte (counter = 15), go to ISSUE and reset the counter to 0.
- ISSUE: core_start = 1 for exactly this one cycle; in_ready = 0; go to WAIT. core_data, core_key and core_encrypt are held stable from ISSUE until the block returns to FILL.
- WAIT:
  - Count cycles from 0.
  - If core_done is sampled high: capture core_result into the shift register and go to DRAIN. out_valid rises the cycle after core_done is sampled.
  - Else, if the wait count reaches TIMEOUT_CYCLES-1: pulse timeout_err for one cycle, discard the block, go to FILL.
  - The nominal wrapper returns core_done 2 cycles after core_start.
- DRAIN:
  - out_valid = 1; out_data = shift[127:120].
  - On out_valid & out_ready: shift left by 8 and increment the byte counter.
  - On the 16th handshake: blk_count += 1, return to FILL. in_ready goes high the next cycle.
  - out_valid/out_data hold stable while out_ready = 0.
- core_done outside WAIT is ignored; no capture, no error.
- in_valid outside FILL is ignored; no bytes are lost because in_ready = 0 there.
- Single-block occupancy: no overlap of fill and drain.
- Best-case block latency (in_valid and out_ready held high): 16 fill + 1 ISSUE + 2 WAIT + 16 drain cycles.

Test Plan:
1. FIPS-197 encrypt: key 000102…0f, encrypt = 1, feed bytes 00,11,22,…,ff back-to-back with out_ready = 1 → exactly one core_start pulse; out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; blk_count = 1.
2. Decrypt round trip: same key, encrypt = 0, feed 69c4…c55a → output 00112233445566778899aabbccddeeff. Toggling encrypt/key_in after byte 0 does not affect the result.
3. Backpressure: hold out_ready = 0 for 5 cycles at byte 3 and at byte 15 of the drain → out_data held stable, no byte lost or duplicated, in_ready stays 0 until the 16th handshake.
4. Timeout: stub core never asserts core_done → timeout_err pulses exactly TIMEOUT_CYCLES (8) cycles after WAIT entry; returns to FILL; blk_count unchanged; next block processes normally.
5. Gapped input and spurious done: in_valid toggled randomly during FILL, plus a core_done pulse injected during FILL → byte assembly correct, injected done ignored, single core_start issued after the 16th byte.
6. Reset mid-DRAIN after 7 bytes out → all outputs return to reset values immediately; a following block drains a full 16 bytes; blk_count restarts from 0.
